// File: rtl/waveform_word_server.sv
// =============================================================================
// Module   : waveform_word_server
// Brief    : BRAM-backed waveform sample server with a four-phase word handshake.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module waveform_word_server #(
    parameter int DAC_DATA_WID = 20,
    parameter int ADDR_WID     = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_we,
    input  logic [ADDR_WID-1:0]     load_addr,
    input  logic [DAC_DATA_WID-1:0] load_data,
    input  logic                    len_we,
    input  logic [ADDR_WID:0]       len_in,
    input  logic                    word_next,
    input  logic                    word_rst,
    output logic [DAC_DATA_WID-1:0] word,
    output logic                    word_ok,
    output logic                    word_last,
    output logic                    busy
);

    localparam int DEPTH   = 2 ** ADDR_WID;
    localparam int IDX_WID = ADDR_WID + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [IDX_WID-1:0]      r_index;
    logic [IDX_WID-1:0]      w_index_nx;
    logic [IDX_WID-1:0]      r_len;
    logic [IDX_WID-1:0]      w_len_m1;
    logic                    w_is_last;
    logic [DAC_DATA_WID-1:0] r_word;
    logic [DAC_DATA_WID-1:0] w_word_nx;
    logic                    r_ok;
    logic                    w_ok_nx;
    logic                    r_last;
    logic                    w_last_nx;
    logic [DAC_DATA_WID-1:0] r_rdata;
    logic [DAC_DATA_WID-1:0] r_mem [DEPTH];

    // Read port samples the current index every cycle; the value captured on
    // the IDLE->READ edge is the one consumed in READ.
    always_ff @(posedge clk) begin
        if (load_we) begin
            r_mem[load_addr] <= load_data;
        end
        r_rdata <= r_mem[r_index[ADDR_WID-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len <= '0;
        end else if (len_we) begin
            r_len <= len_in;
        end
    end

    assign w_len_m1  = r_len - IDX_WID'(1);
    assign w_is_last = (r_index == w_len_m1);

    always_comb begin
        w_state_nx = r_state;
        w_index_nx = r_index;
        w_word_nx  = r_word;
        w_ok_nx    = r_ok;
        w_last_nx  = r_last;
        if (word_rst) begin
            w_state_nx = IDLE;
            w_index_nx = '0;
            w_ok_nx    = 1'b0;
            w_last_nx  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (word_next) begin
                        w_state_nx = READ;
                    end
                end
                READ: begin
                    w_ok_nx    = 1'b1;
                    w_state_nx = ACK;
                    // An empty waveform answers with a zero sample flagged last.
                    if (r_len == '0) begin
                        w_word_nx = '0;
                        w_last_nx = 1'b1;
                    end else begin
                        w_word_nx  = r_rdata;
                        w_last_nx  = w_is_last;
                        w_index_nx = w_is_last ? '0 : r_index + IDX_WID'(1);
                    end
                end
                ACK: begin
                    if (!word_next) begin
                        w_ok_nx    = 1'b0;
                        w_state_nx = IDLE;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_index <= '0;
            r_word  <= '0;
            r_ok    <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_index <= w_index_nx;
            r_word  <= w_word_nx;
            r_ok    <= w_ok_nx;
            r_last  <= w_last_nx;
        end
    end

    assign word      = r_word;
    assign word_ok   = r_ok;
    assign word_last = r_last;
    assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_waveform_word_server.sv
// =============================================================================
// Module   : tb_waveform_word_server
// Brief    : Scoreboard bench for waveform_word_server against a sample-list model.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_waveform_word_server;

    localparam int DW = 20;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_we = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          len_we = 1'b0;
    logic [AW:0]   len_in = '0;
    logic          word_next = 1'b0;
    logic          word_rst = 1'b0;
    logic [DW-1:0] word;
    logic          word_ok;
    logic          word_last;
    logic          busy;

    int tests = 0;
    int fails = 0;

    logic [DW:0]   exp_q[$];
    logic [DW-1:0] m_ram [1024];
    int            m_len = 0;
    int            m_idx = 0;
    logic          prev_ok = 1'b0;

    waveform_word_server #(.DAC_DATA_WID(DW), .ADDR_WID(AW)) dut (
        .clk(clk), .rst(rst),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .len_we(len_we), .len_in(len_in),
        .word_next(word_next), .word_rst(word_rst),
        .word(word), .word_ok(word_ok), .word_last(word_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every new word_ok assertion must match the oldest expected sample.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (word_ok && !prev_ok) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_word actual=%h/%b required=none", word, word_last);
            end else begin
                e = exp_q.pop_front();
                if ({word, word_last} !== e) begin
                    fails++;
                    $display("FAIL served_word actual=%h/%b required=%h/%b",
                             word, word_last, e[DW:1], e[0]);
                end
            end
        end
        prev_ok = word_ok;
    end

    // Reference: the waveform is the list m_ram[0..m_len-1] played cyclically.
    task automatic model_next(output logic [DW-1:0] w, output logic l);
        if (m_len == 0) begin
            w = '0;
            l = 1'b1;
        end else begin
            w = m_ram[m_idx];
            l = (m_idx == m_len - 1);
            m_idx = (m_idx + 1) % m_len;
        end
    endtask

    task automatic write_word(input int addr, input logic [DW-1:0] data);
        load_addr = AW'(addr);
        load_data = data;
        load_we   = 1'b1;
        @(negedge clk);
        load_we   = 1'b0;
        m_ram[addr] = data;
    endtask

    task automatic set_len(input int v);
        len_in = (AW+1)'(v);
        len_we = 1'b1;
        @(negedge clk);
        len_we = 1'b0;
        m_len  = v;
    endtask

    task automatic begin_req();
        logic [DW-1:0] w;
        logic          l;
        int            cnt;
        model_next(w, l);
        exp_q.push_back({w, l});
        word_next = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!word_ok && cnt < 8);
        check("ok_latency", cnt, 2);
    endtask

    task automatic end_req();
        word_next = 1'b0;
        @(negedge clk);
        check("ok_release", {31'd0, word_ok}, 0);
        check("idle_after_ack", {31'd0, busy}, 0);
    endtask

    task automatic request();
        begin_req();
        end_req();
    endtask

    task automatic rewind(input int n);
        word_rst = 1'b1;
        repeat (n) begin
            @(negedge clk);
            check("ok_during_rewind", {31'd0, word_ok}, 0);
        end
        word_rst = 1'b0;
        m_idx = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_word", {12'd0, word}, 0);
        check("reset_ok", {31'd0, word_ok}, 0);
        check("reset_last", {31'd0, word_last}, 0);
        check("reset_busy", {31'd0, busy}, 0);

        // Basic ordered playback and wrap.
        write_word(0, 20'h11111);
        write_word(1, 20'h22222);
        write_word(2, 20'h33333);
        write_word(3, 20'h44444);
        set_len(4);
        repeat (5) request();

        // Two more words, then a rewind held with word_next high.
        request();
        request();
        word_next = 1'b1;
        rewind(3);
        begin_req();
        end_req();

        // Rewind during ACK while word_next stays high.
        begin_req();
        word_rst = 1'b1;
        @(negedge clk);
        check("abort_ok_drop", {31'd0, word_ok}, 0);
        check("abort_last_drop", {31'd0, word_last}, 0);
        word_rst = 1'b0;
        m_idx = 0;
        begin_req();
        end_req();

        // Load write during ACK is visible to the following request.
        rewind(1);
        begin_req();
        write_word(1, 20'h5A5A5);
        end_req();
        request();

        // Empty waveform.
        set_len(0);
        request();
        request();

        // Randomized playback.
        for (int a = 0; a < 16; a++) write_word(a, DW'($urandom));
        set_len(int'($urandom_range(1, 16)));
        rewind(1);
        for (int it = 0; it < 80; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                request();
            end else if (r == 6) begin
                rewind(int'($urandom_range(1, 3)));
            end else if (r == 7) begin
                set_len(int'($urandom_range(0, 16)));
                rewind(1);
            end else begin
                write_word(int'($urandom_range(0, 15)), DW'($urandom));
            end
        end

        // Asynchronous reset in the middle of READ.
        set_len(4);
        rewind(1);
        word_next = 1'b1;
        @(posedge clk);
        #1;
        check("busy_in_read", {31'd0, busy}, 1);
        rst = 1'b1;
        #1;
        check("arst_word", {12'd0, word}, 0);
        check("arst_ok", {31'd0, word_ok}, 0);
        check("arst_last", {31'd0, word_last}, 0);
        check("arst_busy", {31'd0, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        word_next = 1'b0;
        m_len = 0;
        m_idx = 0;
        @(negedge clk);
        request();

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
